// File: rtl/mp3_data_feeder.sv
// Byte FIFO feeding the MP3 data shifter: one start per byte while DREQ is high. Launch is one cycle after the
// deciding edge; writes into a full FIFO are dropped (flagged by ovf) unless a pop frees the slot in that same cycle.
module mp3_data_feeder #(
  parameter int DEPTH_LOG2 = 4,
  parameter int GUARD_CYC  = 2
) (
  input  logic                  cpu_clock,
  input  logic                  rst,
  input  logic                  wr_stb,
  input  logic [7:0]            wr_data,
  input  logic                  flush,
  input  logic                  ovf_clr,
  input  logic                  mp3_req,
  input  logic                  spi_rdy,
  output logic                  md_start,
  output logic [7:0]            md_din,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  ovf,
  output logic                  busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {ST_IDLE, ST_GUARD, ST_WAIT} state_t;

  state_t                  state, state_nxt;
  logic [2:0]              guard_cnt, guard_nxt;
  logic [DEPTH_LOG2-1:0]   wptr, rptr;
  logic [7:0]              mem [DEPTH];
  logic                    dreq_m, dreq_s;
  logic                    launch, accept, drop;
  logic [DEPTH_LOG2:0]     count_nxt;
  logic                    busy_nxt;

  always_ff @(posedge cpu_clock) begin
    if (rst) begin
      state     <= ST_IDLE;
      guard_cnt <= 3'd0;
    end else begin
      state     <= state_nxt;
      guard_cnt <= guard_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    guard_nxt = guard_cnt;
    launch    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && dreq_s && spi_rdy && !flush) begin
          launch    = 1'b1;
          state_nxt = ST_GUARD;
          guard_nxt = 3'(GUARD_CYC);
        end
      end
      ST_GUARD: begin
        // spi_rdy may still show the shifter's pre-start idle here, so it is not looked at
        guard_nxt = guard_cnt - 3'd1;
        if (guard_cnt <= 3'd1) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (spi_rdy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    accept    = wr_stb && !flush && (!fifo_full || launch);
    drop      = wr_stb && !flush && fifo_full && !launch;
    count_nxt = fifo_count;
    if (flush) begin
      count_nxt = '0;
    end else if (accept && !launch) begin
      count_nxt = fifo_count + (DEPTH_LOG2+1)'(1);
    end else if (launch && !accept) begin
      count_nxt = fifo_count - (DEPTH_LOG2+1)'(1);
    end
    busy_nxt = (count_nxt != '0) || (state_nxt != ST_IDLE);
  end

  always_ff @(posedge cpu_clock) begin
    if (rst) begin
      dreq_m <= 1'b0;
      dreq_s <= 1'b0;
    end else begin
      dreq_m <= mp3_req;
      dreq_s <= dreq_m;
    end
  end

  always_ff @(posedge cpu_clock) begin
    if (!rst && accept) mem[wptr] <= wr_data;
  end

  always_ff @(posedge cpu_clock) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      ovf        <= 1'b0;
      md_start   <= 1'b0;
      md_din     <= 8'h00;
      busy       <= 1'b0;
    end else begin
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (accept) wptr <= wptr + DEPTH_LOG2'(1);
        if (launch) rptr <= rptr + DEPTH_LOG2'(1);
      end
      fifo_count <= count_nxt;
      fifo_empty <= (count_nxt == '0);
      fifo_full  <= (count_nxt == (DEPTH_LOG2+1)'(DEPTH));
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      md_start <= launch;
      if (launch) md_din <= mem[rptr];
      busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_mp3_data_feeder.sv
// Directed bench for mp3_data_feeder with a small shifter model that stays busy for a few cycles after each start.
module tb_mp3_data_feeder;

  logic       cpu_clock = 1'b0;
  logic       rst = 1'b1;
  logic       wr_stb = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       mp3_req = 1'b0;
  logic       spi_rdy;
  logic       md_start;
  logic [7:0] md_din;
  logic       fifo_empty;
  logic       fifo_full;
  logic [4:0] fifo_count;
  logic       ovf;
  logic       busy;

  logic       stall = 1'b0;
  logic [2:0] sh_cnt = 3'd0;
  logic [7:0] sent [$];
  logic [7:0] exp_q [$];
  int         checks = 0;
  int         errors = 0;

  always #5 cpu_clock = ~cpu_clock;

  mp3_data_feeder #(.DEPTH_LOG2(4), .GUARD_CYC(2)) dut (
    .cpu_clock (cpu_clock),
    .rst       (rst),
    .wr_stb    (wr_stb),
    .wr_data   (wr_data),
    .flush     (flush),
    .ovf_clr   (ovf_clr),
    .mp3_req   (mp3_req),
    .spi_rdy   (spi_rdy),
    .md_start  (md_start),
    .md_din    (md_din),
    .fifo_empty(fifo_empty),
    .fifo_full (fifo_full),
    .fifo_count(fifo_count),
    .ovf       (ovf),
    .busy      (busy)
  );

  // shifter: busy for three cycles after it samples a start
  always @(posedge cpu_clock) begin
    if (md_start) sh_cnt <= 3'd3;
    else if (sh_cnt != 3'd0) sh_cnt <= sh_cnt - 3'd1;
  end
  assign spi_rdy = !stall && (sh_cnt == 3'd0);

  always @(negedge cpu_clock) begin
    if (md_start) sent.push_back(md_din);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge cpu_clock);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_stb  = 1'b1;
    wr_data = b;
    tick();
    wr_stb  = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input string tag);
    int i;
    for (i = 0; i < 400 && sent.size() < n; i++) begin
      @(negedge cpu_clock);
      #1;
    end
    if (sent.size() < n) check({tag, "_timeout"}, 32'(sent.size()), 32'(n));
  endtask

  task automatic check_sent(input string tag);
    check({tag, "_n"}, 32'(sent.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < sent.size(); i++)
      check($sformatf("%s_%0d", tag, i), 32'(sent[i]), 32'(exp_q[i]));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    rst = 1'b0;
    tick(5);
    check("rst_start", 32'(sent.size()), 0);
    check("rst_empty", 32'(fifo_empty), 1);
    check("rst_full",  32'(fifo_full), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_din",   32'(md_din), 32'h00);
    check("rst_ovf",   32'(ovf), 0);
    check("rst_busy",  32'(busy), 0);

    // single byte
    mp3_req = 1'b1;
    tick(3);
    push(8'hA5);
    check("one_busy", 32'(busy), 1);
    check("one_count", 32'(fifo_count), 1);
    wait_pulses(1, "one");
    tick(20);
    exp_q = '{8'hA5};
    check_sent("one");
    check("one_count0", 32'(fifo_count), 0);
    check("one_idle", 32'(busy), 0);

    // overflow: 17 writes into 16 slots
    mp3_req = 1'b0;
    tick(3);
    sent.delete();
    for (int i = 0; i < 17; i++) push(8'(i));
    check("ovf_full",  32'(fifo_full), 1);
    check("ovf_count", 32'(fifo_count), 16);
    check("ovf_set",   32'(ovf), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(ovf), 0);
    mp3_req = 1'b1;
    wait_pulses(16, "drain");
    tick(30);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    check_sent("drain");
    check("drain_empty", 32'(fifo_empty), 1);

    // write into full FIFO coinciding with a pop
    mp3_req = 1'b0;
    tick(3);
    sent.delete();
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    stall   = 1'b1;
    mp3_req = 1'b1;
    tick(5);
    check("stall_nostart", 32'(sent.size()), 0);
    stall   = 1'b0;
    wr_stb  = 1'b1;
    wr_data = 8'h77;
    tick();
    wr_stb  = 1'b0;
    check("pp_count", 32'(fifo_count), 16);
    check("pp_full",  32'(fifo_full), 1);
    check("pp_ovf",   32'(ovf), 0);
    wait_pulses(17, "pp");
    tick(30);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h20 + i));
    exp_q.push_back(8'h77);
    check_sent("pp");

    // flush during guard
    mp3_req = 1'b0;
    tick(3);
    sent.delete();
    for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
    mp3_req = 1'b1;
    wait_pulses(1, "fl");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_count", 32'(fifo_count), 0);
    check("fl_empty", 32'(fifo_empty), 1);
    tick(30);
    exp_q = '{8'h40};
    check_sent("fl");
    check("fl_busy", 32'(busy), 0);
    check("fl_din",  32'(md_din), 32'h40);

    // DREQ drop mid-stream
    mp3_req = 1'b0;
    tick(3);
    sent.delete();
    for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
    mp3_req = 1'b1;
    wait_pulses(4, "dq");
    mp3_req = 1'b0;
    tick(30);
    check("dq_held_n", 32'(sent.size()), 4);
    check("dq_count",  32'(fifo_count), 2);
    check("dq_busy",   32'(busy), 1);
    mp3_req = 1'b1;
    wait_pulses(6, "dq");
    tick(30);
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(8'(8'h60 + i));
    check_sent("dq");
    check("dq_count0", 32'(fifo_count), 0);

    // reset while waiting on the shifter
    push(8'h99);
    push(8'h98);
    wait_pulses(7, "rw");
    stall = 1'b1;
    tick(5);
    check("rw_busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    check("rw_start", 32'(md_start), 0);
    check("rw_din",   32'(md_din), 32'h00);
    check("rw_count", 32'(fifo_count), 0);
    check("rw_empty", 32'(fifo_empty), 1);
    check("rw_full",  32'(fifo_full), 0);
    check("rw_ovf",   32'(ovf), 0);
    check("rw_busy0", 32'(busy), 0);
    rst   = 1'b0;
    stall = 1'b0;
    tick(20);
    check("rw_nostart", 32'(sent.size()), 7);
    check("rw_idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mp3_data_feeder.md
Name: mp3_data_feeder

Overview:
- Byte FIFO and transfer sequencer between the Z80 port logic and the MP3 data-SPI shifter.
- Z80 port writes are buffered, and bytes are streamed to the MP3 chip's serial data input only while the chip asserts DREQ (mp3_req).
- This takes per-byte DREQ polling and start pulses off the Z80.
- Inputs: byte writes and flush from the port decoder. Outputs: md_din and md_start to the data shifter.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (default 16 bytes).
- GUARD_CYC, 2, cycles after a start pulse during which spi_rdy is ignored. Legal range 1..7.

Ports:
- cpu_clock  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- wr_stb  in  1  one-cycle strobe: push wr_data.
- wr_data  in  8  byte to enqueue.
- flush  in  1  one-cycle strobe: discard all queued bytes.
- ovf_clr  in  1  one-cycle strobe: clear the ovf flag.
- mp3_req  in  1  DREQ from the MP3 chip; asynchronous.
- spi_rdy  in  1  shifter idle (1 = ready to accept a start).
- md_start  out  1  one-cycle start pulse to the shifter.
- md_din  out  8  byte for the shifter; held stable between starts.
- fifo_empty  out  1  no bytes queued.
- fifo_full  out  1  2^DEPTH_LOG2 bytes queued.
- fifo_count  out  DEPTH_LOG2+1  number of queued bytes.
- ovf  out  1  sticky flag: a write was dropped.
- busy  out  1  FIFO not empty, or a byte is in flight.

Behaviour:
- Reset (rst=1 at an edge) sets:
  - pointers and count to 0; fifo_empty=1, fifo_full=0;
  - ovf=0, md_start=0, md_din=8'h00, busy=0;
  - both DREQ synchronizer flops to 0; FSM to IDLE.
- Reset mid-transfer abandons the byte and drives no further md_start.
- DREQ synchronization:
  - 2-flop synchronizer produces dreq_s.
  - mp3_req rising before edge n gives dreq_s=1 after edge n+1.
- FIFO:
  - Circular buffer; read and write pointers are DEPTH_LOG2 bits and wrap naturally.
  - count = writes minus pops, range 0..2^DEPTH_LOG2.
  - All status outputs are registered and valid the cycle after the causing edge.
- Push rules:
  - wr_stb with not full: write at wptr, increment wptr and count.
  - wr_stb with full and no pop in the same cycle: byte dropped, ovf<=1, state otherwise unchanged.
  - wr_stb with full and a pop in the same cycle: write accepted, count stays at max.
  - Push and pop in the same cycle with not full: count unchanged.
  - ovf_clr clears ovf. If ovf_clr and a dropped write occur in the same cycle, set wins.
- Flush:
  - Sets rptr=wptr=0 and count=0.
  - Takes priority over a same-cycle wr_stb (the byte is discarded, ovf is not set) and over a same-cycle pop (no md_start is issued).
  - A byte already launched completes normally.
- FSM:
  - IDLE: if !fifo_empty && dreq_s && spi_rdy && !flush, then next cycle md_start=1 and md_din=head byte, pop (rptr+1, count-1), go to GUARD with guard counter = GUARD_CYC. Else stay.
  - GUARD: md_start=0; decrement the counter; at 0 go to WAIT. spi_rdy is ignored here.
  - WAIT: when spi_rdy=1, go to IDLE.
- Throughput:
  - A new start can issue on the cycle after returning to IDLE.
  - Minimum spacing between start pulses is GUARD_CYC+2 cycles plus the shifter busy time.
- DREQ deassertion stops only new launches. An in-flight byte always finishes.
- md_din changes only together with md_start=1.
- busy = !fifo_empty OR state != IDLE.

Test Plan:
- Reset, then idle with mp3_req=0 and spi_rdy=1 -> md_start stays 0, fifo_empty=1, count=0, md_din=00.
- Push 8'hA5, mp3_req=1, spi_rdy=1 -> exactly one md_start pulse with md_din=A5; count returns to 0; busy drops after spi_rdy is seen.
- Push 17 bytes 00..10 with mp3_req=0 -> fifo_full=1, count=16, ovf=1. Then ovf_clr -> ovf=0. Then raise DREQ -> starts carry 00..0F in order, 10 is never sent.
- Full FIFO, stall the shifter (spi_rdy=0), release so a pop coincides with wr_stb of 8'h77 -> ovf stays 0, count stays 16, 77 emerges last.
- Queue 5 bytes, launch the first, assert flush during GUARD -> the first byte completes, count=0, no further md_start.
- Drop mp3_req mid-stream after 3 of 6 bytes -> the in-flight byte finishes, count=2 held, resume on the next mp3_req high. Then assert rst during WAIT -> all outputs return to reset values.
